sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO: circular-buffer storage with independent write and read handshakes, occupancy count, programmable almost-full flag and overflow/underflow error pulses. It is the successor to the fixed 4-deep, 1-bit serial shift FIFO. It is generalised in data width and depth, and adds flow control, so producer and consumer stages in the datapath can run at different rates.

---
 rtl/sync_fifo_param.sv | 108 ++++++++++
 tb/tb_sync_fifo_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock FIFO built on a circular buffer, with independent write and
// read handshakes, an occupancy count, a programmable almost-full flag and
// one-cycle overflow/underflow error pulses.
//
// Parameters:
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of entries (power of two, >= 2)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous reset, active low
//   wr_en        in   write request
//   wr_data      in   write word
//   rd_en        in   read request
//   rd_data      out  read word, registered, holds when no read is accepted
//   rd_valid     out  rd_data carries a freshly read word this cycle
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   count        out  occupancy 0..DEPTH
//   overflow     out  pulse one cycle after a write request while full
//   underflow    out  pulse one cycle after a read request while empty
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic          AF_RST  = (AF_LEVEL == 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             wr_acc;
    logic             rd_acc;
    logic [CW-1:0]    count_next;

    // Acceptance looks only at the registered flags: no same-cycle bypass,
    // so a write into an empty FIFO cannot be read in that same cycle.
    always_comb begin
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        count_next = count + CW'(wr_acc) - CW'(rd_acc);
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp          <= '0;
            rp          <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= AF_RST;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (wr_acc) begin
                wp <= wp + AW'(1);
            end
            if (rd_acc) begin
                rp      <= rp + AW'(1);
                rd_data <= mem[rp];
            end
            rd_valid <= rd_acc;

            // Flags are derived from the next count so they line up with it.
            count       <= count_next;
            full        <= (count_next == DEPTH_C);
            empty       <= (count_next == '0);
            almost_full <= (count_next >= AF_C);

            overflow    <= wr_en && full;
            underflow   <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = DEPTH - 2;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue holding the FIFO contents plus the last
    // registered read/error outputs.
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_rd_data;
    logic             m_rd_valid;
    logic             m_ovf;
    logic             m_udf;

    sync_fifo_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of requests, advance the model, and return 1 time unit
    // after the rising edge with inputs idled.
    task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re);
        int  n;
        logic wacc;
        logic racc;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        n       = q.size();
        wacc    = we && (n != DEPTH);
        racc    = re && (n != 0);
        m_ovf   = we && (n == DEPTH);
        m_udf   = re && (n == 0);
        m_rd_valid = racc;
        if (racc) m_rd_data = q.pop_front();
        if (wacc) q.push_back(wd);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        #2;
        apply_reset();
        #1;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b want=0", almost_full); end
        release_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, WIDTH'(i), 1'b0);
            total++; if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d want=%0d", i, count, i + 1); end
            total++; if (almost_full !== (i + 1 >= AF_LEVEL)) begin bad++; $display("FAIL fill_af i=%0d got=%b want=%b", i, almost_full, (i + 1 >= AF_LEVEL)); end
            total++; if (full !== (i + 1 == DEPTH)) begin bad++; $display("FAIL fill_full i=%0d got=%b want=%b", i, full, (i + 1 == DEPTH)); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL drain_valid i=%0d got=%b want=1", i, rd_valid); end
            total++; if (rd_data !== WIDTH'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h want=%h", i, rd_data, WIDTH'(i)); end
            total++; if (count !== 5'(DEPTH - 1 - i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d want=%0d", i, count, DEPTH - 1 - i); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
    endtask

    task automatic test_wrap();
        int peak;
        for (int i = 0; i < 10; i++) step(1'b1, 8'h10 + WIDTH'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1);
            total++; if (rd_data !== 8'h10 + WIDTH'(i)) begin bad++; $display("FAIL wrap1_data i=%0d got=%h want=%h", i, rd_data, 8'h10 + WIDTH'(i)); end
        end
        peak = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'hA0 + WIDTH'(i), 1'b0);
            if (int'(count) > peak) peak = int'(count);
        end
        total++; if (peak != 12) begin bad++; $display("FAIL wrap_peak got=%0d want=12", peak); end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'h00, 1'b1);
            total++; if (rd_data !== 8'hA0 + WIDTH'(i)) begin bad++; $display("FAIL wrap2_data i=%0d got=%h want=%h", i, rd_data, 8'hA0 + WIDTH'(i)); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", empty); end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h60 + WIDTH'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", count); end
        step(1'b0, 8'h00, 1'b0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            total++; if (rd_data !== 8'h60 + WIDTH'(i)) begin bad++; $display("FAIL ovf_data i=%0d got=%h want=%h", i, rd_data, 8'h60 + WIDTH'(i)); end
        end
        step(1'b0, 8'h00, 1'b1);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_pulse got=%b want=1", underflow); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL udf_valid got=%b want=0", rd_valid); end
        total++; if (rd_data !== 8'h6F) begin bad++; $display("FAIL udf_hold got=%h want=6f", rd_data); end
        step(1'b0, 8'h00, 1'b0);
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b want=0", underflow); end
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + WIDTH'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            d = WIDTH'($urandom);
            step(1'b1, d, 1'b1);
            total++; if (count !== 5'd5) begin bad++; $display("FAIL sim_count i=%0d got=%0d want=5", i, count); end
            total++; if (rd_data !== m_rd_data) begin bad++; $display("FAIL sim_data i=%0d got=%h want=%h", i, rd_data, m_rd_data); end
        end
        while (q.size() < DEPTH) step(1'b1, WIDTH'($urandom), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_both_ovf got=%b want=1", overflow); end
        total++; if (count !== 5'd15) begin bad++; $display("FAIL full_both_count got=%0d want=15", count); end
        total++; if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin bad++; $display("FAIL full_both_read got=%b/%h want=1/%h", rd_valid, rd_data, m_rd_data); end
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL empty_both_count got=%0d want=1", count); end
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL empty_both_udf got=%b want=1", underflow); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL empty_both_valid got=%b want=0", rd_valid); end
        step(1'b0, 8'h00, 1'b1);
        total++; if (rd_data !== 8'h33) begin bad++; $display("FAIL empty_both_data got=%h want=33", rd_data); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) step(1'b1, WIDTH'($urandom), 1'b0);
        total++; if (count !== 5'd9) begin bad++; $display("FAIL mid_pre_count got=%0d want=9", count); end
        #3;
        apply_reset();
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b want=1", empty); end
        release_reset();
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin bad++; $display("FAIL mid_read got=%b/%h want=1/5a", rd_valid, rd_data); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_end_empty got=%b want=1", empty); end
    endtask

    task automatic test_random();
        logic we;
        logic re;
        for (int i = 0; i < 400; i++) begin
            // Bias the mix in phases so the FIFO visits both boundaries.
            if (i < 130)      begin we = ($urandom_range(0, 3) != 0); re = ($urandom_range(0, 3) == 0); end
            else if (i < 260) begin we = ($urandom_range(0, 3) == 0); re = ($urandom_range(0, 3) != 0); end
            else              begin we = $urandom_range(0, 1); re = $urandom_range(0, 1); end
            step(we, WIDTH'($urandom), re);
            total++;
            if (count !== 5'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
                almost_full !== (q.size() >= AF_LEVEL) || rd_valid !== m_rd_valid || rd_data !== m_rd_data ||
                overflow !== m_ovf || underflow !== m_udf) begin
                bad++;
                $display("FAIL rand i=%0d got cnt=%0d f=%b e=%b af=%b v=%b d=%h o=%b u=%b want cnt=%0d f=%b e=%b af=%b v=%b d=%h o=%b u=%b",
                         i, count, full, empty, almost_full, rd_valid, rd_data, overflow, underflow,
                         q.size(), (q.size() == DEPTH), (q.size() == 0), (q.size() >= AF_LEVEL),
                         m_rd_valid, m_rd_data, m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        apply_reset();
        repeat (2) @(posedge clk);
        release_reset();
        test_reset();
        test_fill_drain();
        test_wrap();
        test_boundary();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
